// File: rtl/ram_pkg.sv
// ram_pkg: shared types and constants for multi_port_ram and its read ports.
// Holds the clear/run state encoding, the address-width helper and the
// reset value of a memory word.
package ram_pkg;

  // Controller states: CLEAR zeroes the array after reset, RUN serves traffic.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } ram_state_e;

  // Reset value of every bit of a word; replicate to WIDTH where needed.
  localparam logic RESET_BIT = 1'b0;

  // Address width for a given depth; never narrower than one bit.
  function automatic int calc_aw(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/ram_read_port.sv
// ram_read_port: one registered read port of multi_port_ram.
// Holds the output data register, the valid flag, the address range check
// and, when RAM_BYPASS_EN is defined, the write-first forwarding mux.
// Without RAM_BYPASS_EN the port is read-first and the write-side inputs
// are left unused.
module ram_read_port
  import ram_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = calc_aw(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ready,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  input  logic [WIDTH-1:0] rword,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] rdata_reg;
  logic [WIDTH-1:0] rdata_next;
  logic             rvalid_reg;
  logic             rvalid_next;
  logic             in_range;
  logic [WIDTH-1:0] word_sel;

  assign in_range = ({1'b0, raddr} < DEPTH_W);

`ifdef RAM_BYPASS_EN
  // Forward the incoming write when it targets the word being read.
  always_comb begin
    word_sel = rword;
    if (we && (waddr == raddr)) begin
      word_sel = wdata;
    end
  end
`else
  // Read-first: the pre-write contents are returned on a collision.
  logic unused_bypass;
  assign unused_bypass = ^{we, waddr, wdata};
  assign word_sel      = rword;
`endif

  // Next read data/valid: capture on enable while ready, else hold data.
  always_comb begin
    rdata_next  = rdata_reg;
    rvalid_next = 1'b0;
    if (ready && re) begin
      rvalid_next = 1'b1;
      rdata_next  = in_range ? word_sel : {WIDTH{RESET_BIT}};
    end
  end

  // Output registers; cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      rdata_reg  <= {WIDTH{RESET_BIT}};
      rvalid_reg <= 1'b0;
    end else begin
      rdata_reg  <= rdata_next;
      rvalid_reg <= rvalid_next;
    end
  end

  assign rdata  = rdata_reg;
  assign rvalid = rvalid_reg;

endmodule

// File: rtl/multi_port_ram.sv
// multi_port_ram: DEPTH x WIDTH register-file RAM, one write port and two
// registered read ports. After reset the array is zeroed one word per cycle
// before ready rises. Define RAM_BYPASS_EN for write-first forwarding on
// same-address write/read collisions; the default build is read-first.
module multi_port_ram
  import ram_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = calc_aw(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re1,
  input  logic [AW-1:0]    raddr1,
  input  logic             re2,
  input  logic [AW-1:0]    raddr2,
  output logic [WIDTH-1:0] rdata1,
  output logic             rvalid1,
  output logic [WIDTH-1:0] rdata2,
  output logic             rvalid2,
  output logic             ready
);

  localparam int          NPORTS   = 2;
  localparam logic [AW:0] DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];

  ram_state_e    state_reg;
  ram_state_e    state_next;
  logic [AW-1:0] ptr_reg;
  logic [AW-1:0] ptr_next;
  logic          ready_reg;
  logic          ready_next;
  logic          clear_en;
  logic          wr_en;

  // Clear/run controller registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= CLEAR;
      ptr_reg   <= '0;
      ready_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      ready_reg <= ready_next;
    end
  end

  // Controller next state: walk the pointer across the array, then run.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    ready_next = ready_reg;
    clear_en   = 1'b0;
    case (state_reg)
      CLEAR: begin
        clear_en = 1'b1;
        if (ptr_reg == LAST_PTR) begin
          state_next = RUN;
          ready_next = 1'b1;
          ptr_next   = '0;
        end else begin
          ptr_next = ptr_reg + 1'b1;
        end
      end
      RUN: begin
        ready_next = 1'b1;
      end
      default: begin
        state_next = CLEAR;
        ready_next = 1'b0;
      end
    endcase
  end

  // Writes are accepted only in RUN and only for in-range addresses.
  assign wr_en = (state_reg == RUN) && we && ({1'b0, waddr} < DEPTH_W);

  // Memory array: cleared word by word during CLEAR, untouched under reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (clear_en) begin
        mem[ptr_reg] <= {WIDTH{RESET_BIT}};
      end else if (wr_en) begin
        mem[waddr] <= wdata;
      end
    end
  end

  logic             re_vec    [NPORTS];
  logic [AW-1:0]    raddr_vec [NPORTS];
  logic [WIDTH-1:0] rdata_vec [NPORTS];
  logic             rvalid_vec[NPORTS];

  assign re_vec[0]    = re1;
  assign re_vec[1]    = re2;
  assign raddr_vec[0] = raddr1;
  assign raddr_vec[1] = raddr2;

  genvar gi;
  generate
    for (gi = 0; gi < NPORTS; gi++) begin : g_rd
      logic [WIDTH-1:0] word;
      // Out-of-range addresses are masked inside the port.
      assign word = mem[raddr_vec[gi]];

      ram_read_port #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
      ) u_port (
        .clock  (clock),
        .reset  (reset),
        .ready  (ready_reg),
        .re     (re_vec[gi]),
        .raddr  (raddr_vec[gi]),
        .rword  (word),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .rdata  (rdata_vec[gi]),
        .rvalid (rvalid_vec[gi])
      );
    end
  endgenerate

  assign rdata1  = rdata_vec[0];
  assign rvalid1 = rvalid_vec[0];
  assign rdata2  = rdata_vec[1];
  assign rvalid2 = rvalid_vec[1];
  assign ready   = ready_reg;

endmodule

// File: tb/tb_multi_port_ram.sv
// tb_multi_port_ram: directed self-checking bench for multi_port_ram.
// Instance "a" is the 16-word build, instance "b" a 12-word build used for
// out-of-range addressing. Collision expectations follow RAM_BYPASS_EN.
module tb_multi_port_ram;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // 16-word instance
  logic       a_reset, a_we, a_re1, a_re2;
  logic [3:0] a_waddr, a_raddr1, a_raddr2;
  logic [7:0] a_wdata, a_rdata1, a_rdata2;
  logic       a_rvalid1, a_rvalid2, a_ready;

  // 12-word instance
  logic       b_reset, b_we, b_re1, b_re2;
  logic [3:0] b_waddr, b_raddr1, b_raddr2;
  logic [7:0] b_wdata, b_rdata1, b_rdata2;
  logic       b_rvalid1, b_rvalid2, b_ready;

  int n_cmp = 0;
  int n_err = 0;

  multi_port_ram #(.WIDTH(8), .DEPTH(16)) u_dut_a (
    .clock(clock), .reset(a_reset), .we(a_we), .waddr(a_waddr), .wdata(a_wdata),
    .re1(a_re1), .raddr1(a_raddr1), .re2(a_re2), .raddr2(a_raddr2),
    .rdata1(a_rdata1), .rvalid1(a_rvalid1), .rdata2(a_rdata2), .rvalid2(a_rvalid2),
    .ready(a_ready)
  );

  multi_port_ram #(.WIDTH(8), .DEPTH(12)) u_dut_b (
    .clock(clock), .reset(b_reset), .we(b_we), .waddr(b_waddr), .wdata(b_wdata),
    .re1(b_re1), .raddr1(b_raddr1), .re2(b_re2), .raddr2(b_raddr2),
    .rdata1(b_rdata1), .rvalid1(b_rvalid1), .rdata2(b_rdata2), .rvalid2(b_rvalid2),
    .ready(b_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic a_idle();
    a_we = 1'b0; a_re1 = 1'b0; a_re2 = 1'b0;
    a_waddr = 4'd0; a_wdata = 8'd0; a_raddr1 = 4'd0; a_raddr2 = 4'd0;
  endtask

  task automatic a_write(input logic [3:0] addr, input logic [7:0] data);
    a_idle();
    a_we = 1'b1; a_waddr = addr; a_wdata = data;
    step();
    a_idle();
  endtask

  logic [7:0] coll_exp;

  initial begin
    a_idle();
    b_we = 1'b0; b_re1 = 1'b0; b_re2 = 1'b0;
    b_waddr = 4'd0; b_wdata = 8'd0; b_raddr1 = 4'd0; b_raddr2 = 4'd0;
    a_reset = 1'b1;
    b_reset = 1'b1;

    // Reset held for two edges
    step();
    step();
    chk("reset_ready", {31'd0, a_ready}, 32'd0);
    chk("reset_rdata1", {24'd0, a_rdata1}, 32'd0);
    chk("reset_rvalid1", {31'd0, a_rvalid1}, 32'd0);
    chk("reset_rdata2", {24'd0, a_rdata2}, 32'd0);
    chk("reset_rvalid2", {31'd0, a_rvalid2}, 32'd0);
    a_reset = 1'b0;

    // Clear: traffic attempted throughout must be ignored
    a_we = 1'b1; a_waddr = 4'd0; a_wdata = 8'hEE;
    a_re1 = 1'b1; a_raddr1 = 4'd0;
    for (int e = 1; e <= 16; e++) begin
      step();
      chk($sformatf("clear_ready_e%0d", e), {31'd0, a_ready}, (e == 16) ? 32'd1 : 32'd0);
      if (e < 16) chk($sformatf("clear_rvalid1_e%0d", e), {31'd0, a_rvalid1}, 32'd0);
    end
    a_idle();

    // Every word reads zero on both ports
    for (int a = 0; a < 16; a++) begin
      a_re1 = 1'b1; a_raddr1 = 4'(a);
      a_re2 = 1'b1; a_raddr2 = 4'(15 - a);
      step();
      chk($sformatf("zero_rd1_a%0d", a), {24'd0, a_rdata1}, 32'd0);
      chk($sformatf("zero_rv1_a%0d", a), {31'd0, a_rvalid1}, 32'd1);
      chk($sformatf("zero_rd2_a%0d", 15 - a), {24'd0, a_rdata2}, 32'd0);
      chk($sformatf("zero_rv2_a%0d", 15 - a), {31'd0, a_rvalid2}, 32'd1);
    end
    a_idle();

    // Write then read on independent ports
    a_write(4'd3, 8'hA5);
    a_write(4'd12, 8'h5A);
    a_re1 = 1'b1; a_raddr1 = 4'd3;
    a_re2 = 1'b1; a_raddr2 = 4'd12;
    step();
    chk("wr_rd1_addr3", {24'd0, a_rdata1}, 32'hA5);
    chk("wr_rd2_addr12", {24'd0, a_rdata2}, 32'h5A);

    // Both ports on the same word
    a_raddr2 = 4'd3;
    step();
    chk("same_rd1", {24'd0, a_rdata1}, 32'hA5);
    chk("same_rd2", {24'd0, a_rdata2}, 32'hA5);
    a_idle();

    // Collision: write and read same address in one cycle
    a_write(4'd7, 8'h11);
    a_we = 1'b1; a_waddr = 4'd7; a_wdata = 8'h22;
    a_re1 = 1'b1; a_raddr1 = 4'd7;
    step();
`ifdef RAM_BYPASS_EN
    coll_exp = 8'h22;
`else
    coll_exp = 8'h11;
`endif
    chk("collision_rd1", {24'd0, a_rdata1}, {24'd0, coll_exp});
    a_idle();
    a_re1 = 1'b1; a_raddr1 = 4'd7;
    step();
    chk("post_collision_rd1", {24'd0, a_rdata1}, 32'h22);

    // Enable low holds data and drops valid
    a_raddr1 = 4'd3;
    step();
    chk("en_rd1", {24'd0, a_rdata1}, 32'hA5);
    chk("en_rv1", {31'd0, a_rvalid1}, 32'd1);
    a_idle();
    a_raddr1 = 4'd7;
    step();
    chk("hold_rd1", {24'd0, a_rdata1}, 32'hA5);
    chk("hold_rv1", {31'd0, a_rvalid1}, 32'd0);
    chk("idle_rv2", {31'd0, a_rvalid2}, 32'd0);

    // Write to word 0 during clear must not have landed
    a_re1 = 1'b1; a_raddr1 = 4'd0;
    step();
    chk("clear_ignored_w0", {24'd0, a_rdata1}, 32'h00);
    a_idle();

    // Reset mid-traffic re-runs the full clear
    a_write(4'd5, 8'hFF);
    a_re1 = 1'b1; a_raddr1 = 4'd5;
    step();
    chk("pre_reset_addr5", {24'd0, a_rdata1}, 32'hFF);
    a_idle();
    a_reset = 1'b1;
    step();
    chk("midreset_ready", {31'd0, a_ready}, 32'd0);
    chk("midreset_rdata1", {24'd0, a_rdata1}, 32'd0);
    a_reset = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      step();
      if (e == 15 || e == 16)
        chk($sformatf("reclear_ready_e%0d", e), {31'd0, a_ready}, (e == 16) ? 32'd1 : 32'd0);
    end
    a_re1 = 1'b1; a_raddr1 = 4'd5;
    step();
    chk("post_reset_addr5", {24'd0, a_rdata1}, 32'h00);
    a_idle();

    // 12-word build: out-of-range handling
    b_reset = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      step();
      if (e == 11 || e == 12)
        chk($sformatf("b_clear_ready_e%0d", e), {31'd0, b_ready}, (e == 12) ? 32'd1 : 32'd0);
    end
    b_we = 1'b1; b_waddr = 4'd1; b_wdata = 8'h3C;
    step();
    b_waddr = 4'd13; b_wdata = 8'h77;
    step();
    b_we = 1'b0;
    b_re1 = 1'b1; b_raddr1 = 4'd1;
    step();
    chk("b_addr1", {24'd0, b_rdata1}, 32'h3C);
    b_raddr1 = 4'd13;
    b_re2 = 1'b1; b_raddr2 = 4'd11;
    step();
    chk("b_oor_rdata1", {24'd0, b_rdata1}, 32'h00);
    chk("b_oor_rvalid1", {31'd0, b_rvalid1}, 32'd1);
    chk("b_addr11", {24'd0, b_rdata2}, 32'h00);
    b_re2 = 1'b0;
    b_raddr1 = 4'd1;
    step();
    chk("b_addr1_unchanged", {24'd0, b_rdata1}, 32'h3C);
    b_re1 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
